// File: rtl/aoc_day1_pkg.sv
// Shared types and default widths for the day-1 dial sequencer.
package aoc_day1_pkg;

    localparam int AMT_W_DEF = 32;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic                 dir_r;
        logic [AMT_W_DEF-1:0] amount;
        logic                 last;
    } cmd_t;

endpackage

// File: rtl/aoc_sync_fifo.sv
// Single-clock FIFO with occupancy counter; head word is presented combinationally.
module aoc_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // a pop frees the slot in the same cycle, so push-while-full is accepted alongside it
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/aoc_day1_seq_ctrl.sv
// Feeds rotation commands from a FIFO into the dial datapath and latches the final zero count.
// Define AOC_SEQ_CHUNK_EN to split amounts above MAX_STEP into multiple beats.
//   state | meaning
//   IDLE  | waiting for start, commands may queue
//   CLEAR | one cycle of dp_rst, counters cleared
//   RUN   | issue one beat per cycle while FIFO non-empty
//   DRAIN | wait for datapath pipeline, then capture result
//   DONE  | result valid, start begins a new run
module aoc_day1_seq_ctrl
    import aoc_day1_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AMT_W    = AMT_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DP_LAT   = 2,
    parameter int MAX_STEP = 99
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_dir_r_i,
    input  logic [AMT_W-1:0] cmd_amount_i,
    input  logic             cmd_last_i,
    output logic             dp_rst_o,
    output logic             dp_en_o,
    output logic             dp_dir_r_o,
    output logic [AMT_W-1:0] dp_data_o,
    input  logic [CNT_W-1:0] dp_zero_count_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] result_o,
    output logic [CNT_W-1:0] cmd_count_o
);
    localparam int        ENT_W      = AMT_W + 2;
    localparam logic [7:0] DRAIN_INIT = 8'(DP_LAT);

    state_e           state_q;
    logic             rdy_q;
    logic             full, empty, push, pop;
    logic [ENT_W-1:0] push_data, head;
    logic             head_dir, head_last;
    logic [AMT_W-1:0] head_amt, beat_amt;
    logic             beat_final;
    logic             dp_rst_q, dp_en_q, dp_dir_q;
    logic [AMT_W-1:0] dp_data_q;
    logic [CNT_W-1:0] result_q, cmd_count_q;
    logic [7:0]       drain_q;

    assign cmd_ready_o = rdy_q & ~full;
    assign push        = cmd_valid_i & cmd_ready_o;
    assign push_data   = {cmd_dir_r_i, cmd_amount_i, cmd_last_i};
    assign {head_dir, head_amt, head_last} = head;

    aoc_sync_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_data),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef AOC_SEQ_CHUNK_EN
    logic             rem_vld_q;
    logic [AMT_W-1:0] rem_q, cur_amt;

    assign cur_amt    = rem_vld_q ? rem_q : head_amt;
    assign beat_final = (cur_amt <= AMT_W'(MAX_STEP));
    assign beat_amt   = beat_final ? cur_amt : AMT_W'(MAX_STEP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_vld_q <= 1'b0;
            rem_q     <= '0;
        end else if (state_q == ST_RUN && !empty) begin
            if (beat_final) begin
                rem_vld_q <= 1'b0;
            end else begin
                rem_vld_q <= 1'b1;
                rem_q     <= cur_amt - AMT_W'(MAX_STEP);
            end
        end
    end
`else
    assign beat_final = 1'b1;
    assign beat_amt   = head_amt;
`endif

    assign pop = (state_q == ST_RUN) & ~empty & beat_final;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b0;
            dp_rst_q    <= 1'b0;
            dp_en_q     <= 1'b0;
            dp_dir_q    <= 1'b0;
            dp_data_q   <= '0;
            result_q    <= '0;
            cmd_count_q <= '0;
            drain_q     <= '0;
        end else begin
            rdy_q    <= 1'b1;
            dp_rst_q <= 1'b0;
            dp_en_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q     <= ST_CLEAR;
                        dp_rst_q    <= 1'b1;
                        result_q    <= '0;
                        cmd_count_q <= '0;
                    end
                end
                ST_CLEAR: state_q <= ST_RUN;
                ST_RUN: begin
                    if (!empty) begin
                        dp_en_q   <= 1'b1;
                        dp_dir_q  <= head_dir;
                        dp_data_q <= beat_amt;
                        if (beat_final) begin
                            if (cmd_count_q != '1) cmd_count_q <= cmd_count_q + CNT_W'(1);
                            if (head_last) begin
                                state_q <= ST_DRAIN;
                                drain_q <= DRAIN_INIT;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0) begin
                        result_q <= dp_zero_count_i;
                        state_q  <= ST_DONE;
                    end else begin
                        drain_q <= drain_q - 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dp_rst_o    = dp_rst_q;
    assign dp_en_o     = dp_en_q;
    assign dp_dir_r_o  = dp_dir_q;
    assign dp_data_o   = dp_data_q;
    assign result_o    = result_q;
    assign cmd_count_o = cmd_count_q;
    assign busy_o      = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_aoc_day1_seq_ctrl.sv
// Directed bench for aoc_day1_seq_ctrl with a two-stage behavioural dial datapath.
module tb_aoc_day1_seq_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic        cmd_valid = 1'b0, cmd_dir_r = 1'b0, cmd_last = 1'b0;
    logic [31:0] cmd_amount = '0;
    logic        cmd_ready, dp_rst, dp_en, dp_dir_r, busy, done;
    logic [31:0] dp_data, result, cmd_count;
    logic [31:0] zc_q = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aoc_day1_seq_ctrl #(.DEPTH(DEPTH), .AMT_W(32), .CNT_W(32), .DP_LAT(2), .MAX_STEP(99)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_dir_r_i(cmd_dir_r), .cmd_amount_i(cmd_amount), .cmd_last_i(cmd_last),
        .dp_rst_o(dp_rst), .dp_en_o(dp_en), .dp_dir_r_o(dp_dir_r), .dp_data_o(dp_data),
        .dp_zero_count_i(zc_q), .busy_o(busy), .done_o(done),
        .result_o(result), .cmd_count_o(cmd_count)
    );

    // dial datapath: input stage register, then position/zero-count update
    int          pos_q = 50;
    logic        st_en_q = 1'b0, st_dir_q = 1'b0;
    logic [31:0] st_amt_q = '0;

    function automatic int step(input int p, input logic d, input logic [31:0] a);
        int m;
        m = int'(a % 100);
        return d ? (p + m) % 100 : (p - m + 100) % 100;
    endfunction

    always @(posedge clk) begin
        if (dp_rst) begin
            pos_q   <= 50;
            zc_q    <= '0;
            st_en_q <= 1'b0;
        end else begin
            st_en_q  <= dp_en;
            st_dir_q <= dp_dir_r;
            st_amt_q <= dp_data;
            if (st_en_q) begin
                pos_q <= step(pos_q, st_dir_q, st_amt_q);
                if (step(pos_q, st_dir_q, st_amt_q) == 0) zc_q <= zc_q + 1;
            end
        end
    end

    int cyc = 0;
    int beats[$];
    int beat_cyc[$];
    int rst_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dp_en) begin
            beats.push_back(int'(dp_data) + (dp_dir_r ? 10000 : 0));
            beat_cyc.push_back(cyc);
        end
        if (dp_rst) rst_pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic d, input int amt, input logic last);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_dir_r = d; cmd_amount = amt; cmd_last = last;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done", done, 1);
    endtask

    task automatic clear_log();
        beats.delete();
        beat_cyc.delete();
        rst_pulses = 0;
    endtask

    task automatic check_zeroed(input string tag);
        chk({tag, "_ready"}, cmd_ready, 0);
        chk({tag, "_dp_rst"}, dp_rst, 0);
        chk({tag, "_dp_en"}, dp_en, 0);
        chk({tag, "_dp_dir"}, dp_dir_r, 0);
        chk({tag, "_dp_data"}, dp_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_cmd_count"}, cmd_count, 0);
    endtask

    int ex_dir[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
    int ex_amt[10] = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};

    task automatic example_run(input string tag);
        clear_log();
        for (int i = 0; i < 8; i++) push(ex_dir[i][0], ex_amt[i], 1'b0);
        pulse_start();
        push(ex_dir[8][0], ex_amt[8], 1'b0);
        push(ex_dir[9][0], ex_amt[9], 1'b1);
        wait_done();
        chk({tag, "_rst_pulses"}, rst_pulses, 1);
        chk({tag, "_nbeats"}, beats.size(), 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s_beat%0d", tag, i), beats[i], ex_amt[i] + ex_dir[i] * 10000);
        chk({tag, "_cmd_count"}, cmd_count, 10);
        chk({tag, "_result"}, result, 3);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int n, k;

        // reset and idle
        #1;
        check_zeroed("reset");
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dp_en) k++;
        end
        chk("idle_dp_en", k, 0);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);

        example_run("example");

        // command queued while DONE survives into the next run; bubble plus zero amount
        push(1'b1, 50, 1'b0);
        clear_log();
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        pulse_start();
        chk("bubble_dp_en", dp_en, 0);
        chk("bubble_dp_data", dp_data, 50);
        chk("busy_running", busy, 1);
        @(negedge clk);
        push(1'b1, 0, 1'b1);
        wait_done();
        chk("bubble_rst_pulses", rst_pulses, 1);
        chk("bubble_nbeats", beats.size(), 2);
        chk("bubble_beat0", beats[0], 10050);
        chk("bubble_beat1", beats[1], 10000);
        chk("bubble_gap", beat_cyc[1] - beat_cyc[0], 4);
        chk("bubble_cmd_count", cmd_count, 2);
        chk("bubble_result", result, 2);

        // backpressure: fill FIFO, then watch ready return after the first pop
        clear_log();
        for (int i = 0; i < DEPTH; i++) push(i[0], i + 1, 1'b0);
        chk("bp_full_ready", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_dir_r = 1'b0; cmd_amount = 9; cmd_last = 1'b0;
        pulse_start();
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_ready_delay", n, 2);
        @(negedge clk);
        cmd_valid = 1'b0;
        push(1'b1, 10, 1'b1);
        wait_done();
        chk("bp_nbeats", beats.size(), DEPTH + 2);
        for (int i = 0; i < DEPTH + 2; i++)
            chk($sformatf("bp_beat%0d", i), beats[i], (i + 1) + ((i % 2) * 10000));
        chk("bp_cmd_count", cmd_count, DEPTH + 2);

        // asynchronous reset during beat 4, then a clean run
        clear_log();
        for (int i = 0; i < 8; i++) push(ex_dir[i][0], ex_amt[i], 1'b0);
        pulse_start();
        k = 0; n = 0;
        while (k < 4 && n < 50) begin
            if (dp_en) k++;
            if (k < 4) @(negedge clk);
            n++;
        end
        chk("midrst_reached_beat4", k, 4);
        rst_n = 1'b0;
        #1;
        check_zeroed("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        example_run("rerun");

        // long rotation
        clear_log();
        push(1'b1, 250, 1'b1);
        pulse_start();
        wait_done();
`ifdef AOC_SEQ_CHUNK_EN
        chk("chunk_nbeats", beats.size(), 3);
        chk("chunk_beat0", beats[0], 10099);
        chk("chunk_beat1", beats[1], 10099);
        chk("chunk_beat2", beats[2], 10052);
        chk("chunk_consecutive", beat_cyc[2] - beat_cyc[0], 2);
`else
        chk("whole_nbeats", beats.size(), 1);
        chk("whole_beat0", beats[0], 10250);
`endif
        chk("long_cmd_count", cmd_count, 1);
        chk("long_result", result, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
